// File: rtl/lighthouse_pkg.sv
// Shared constants for the lighthouse pulse front end: sync code bit
// positions, lighthouse tags, decoder FSM states and 50 MHz timing defaults.
package lighthouse_pkg;

    // Bit positions inside the 3-bit sync code k = {skip, data, axis}
    localparam int CODE_SKIP = 2;
    localparam int CODE_DATA = 1;
    localparam int CODE_AXIS = 0;

    // Lighthouse tags
    localparam logic LH_A = 1'b0;
    localparam logic LH_B = 1'b1;

    // Pulse measurement FSM
    typedef enum logic [1:0] {
        ST_WAIT_LOW,
        ST_IDLE,
        ST_HIGH,
        ST_CLASSIFY
    } state_t;

    // Default timing at 50 MHz
    localparam int DEF_SYNC_BASE_CYCLES    = 3125;
    localparam int DEF_SYNC_STEP_CYCLES    = 521;
    localparam int DEF_SWEEP_MAX_CYCLES    = 1500;
    localparam int DEF_PAIR_GAP_CYCLES     = 25000;
    localparam int DEF_SWEEP_WINDOW_CYCLES = 450000;
    localparam int DEF_TS_BITS             = 20;

endpackage

// File: rtl/lighthouse_sync_classifier.sv
// Combinational pulse-width classifier: sweep / sync / error, plus the
// 3-bit sync code derived from seven threshold comparators.
module lighthouse_sync_classifier #(
    parameter int W         = 20,
    parameter int BASE      = 3125,
    parameter int STEP      = 521,
    parameter int SWEEP_MAX = 1500
) (
    input  logic [W-1:0] width,
    output logic         is_sweep,
    output logic         is_sync,
    output logic [2:0]   code,
    output logic         is_error
);

    localparam int HALF    = STEP / 2;
    localparam int SYNC_LO = BASE - HALF;
    localparam int SYNC_HI = BASE + 7 * STEP + HALF;

    // Class decode and code = number of thresholds BASE + i*STEP - STEP/2 reached
    always_comb begin
        is_sweep = (width <= W'(SWEEP_MAX));
        is_sync  = !is_sweep && (width >= W'(SYNC_LO)) && (width < W'(SYNC_HI));
        is_error = !is_sweep && !is_sync;
        code     = 3'd0;
        for (int i = 1; i <= 7; i++) begin
            if (width >= W'(SYNC_LO + i * STEP))
                code = code + 3'd1;
        end
    end

endmodule

// File: rtl/lighthouse_pulse_decoder.sv
// Lighthouse photodiode front end: synchronises the envelope, measures
// high-pulse widths, tags sync pulses to lighthouse A/B, strobes OOTX data
// bits and reports sweep timing relative to the active (skip=0) sync.
// Optional macro LIGHTHOUSE_GLITCH_FILTER_EN inserts a 4-sample stability
// filter after the synchroniser.
module lighthouse_pulse_decoder
    import lighthouse_pkg::*;
#(
    parameter int SYNC_BASE_CYCLES    = DEF_SYNC_BASE_CYCLES,
    parameter int SYNC_STEP_CYCLES    = DEF_SYNC_STEP_CYCLES,
    parameter int SWEEP_MAX_CYCLES    = DEF_SWEEP_MAX_CYCLES,
    parameter int PAIR_GAP_CYCLES     = DEF_PAIR_GAP_CYCLES,
    parameter int SWEEP_WINDOW_CYCLES = DEF_SWEEP_WINDOW_CYCLES,
    parameter int TS_BITS             = DEF_TS_BITS
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               sensor,
    output logic [1:0]         ootx_bit_valid,
    output logic               ootx_bit,
    output logic               sync_axis,
    output logic               sync_skip,
    output logic               sweep_valid,
    output logic               sweep_lighthouse,
    output logic               sweep_axis,
    output logic [TS_BITS-1:0] sweep_cycles,
    output logic               pulse_error,
    output logic [7:0]         error_count
);

    logic               sync_1, sync_2;
    logic               level, level_d;
    logic               rise, fall;
    logic [TS_BITS-1:0] ts;

    state_t             state;
    logic               rise_pend;
    logic [TS_BITS-1:0] rise_ts;
    logic [TS_BITS-1:0] width;
    logic [TS_BITS-1:0] prev_rise;
    logic               prev_tag;
    logic               active_valid;
    logic [TS_BITS-1:0] active_rise;
    logic               active_lh;
    logic               active_axis;

    logic               is_sweep, is_sync, is_error;
    logic [2:0]         code;
    logic [TS_BITS-1:0] pair_dt, sweep_dt;
    logic               tag_b;

    // Two-flop synchroniser; resets high so a pulse in flight at reset release
    // looks like an ongoing high level and is skipped by WAIT_LOW
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= sensor;
            sync_2 <= sync_1;
        end
    end

`ifdef LIGHTHOUSE_GLITCH_FILTER_EN
    logic       filt;
    logic [1:0] filt_cnt;

    // Stability filter: follow sync_2 only after 4 consecutive differing samples
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            filt     <= 1'b1;
            filt_cnt <= 2'd0;
        end else if (sync_2 == filt) begin
            filt_cnt <= 2'd0;
        end else if (filt_cnt == 2'd3) begin
            filt     <= sync_2;
            filt_cnt <= 2'd0;
        end else begin
            filt_cnt <= filt_cnt + 2'd1;
        end
    end

    assign level = filt;
`else
    assign level = sync_2;
`endif

    // Edge register on the cleaned level
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) level_d <= 1'b1;
        else          level_d <= level;
    end

    assign rise = level & ~level_d;
    assign fall = ~level & level_d;

    // Free-running timestamp, wraps modulo 2^TS_BITS
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) ts <= '0;
        else          ts <= ts + TS_BITS'(1);
    end

    lighthouse_sync_classifier #(
        .W         (TS_BITS),
        .BASE      (SYNC_BASE_CYCLES),
        .STEP      (SYNC_STEP_CYCLES),
        .SWEEP_MAX (SWEEP_MAX_CYCLES)
    ) u_classifier (
        .width    (width),
        .is_sweep (is_sweep),
        .is_sync  (is_sync),
        .code     (code),
        .is_error (is_error)
    );

    // Pair-gap tag decision and sweep time to pulse centre (modular differences)
    always_comb begin
        pair_dt  = rise_ts - prev_rise;
        tag_b    = (prev_tag == LH_A) && (pair_dt < TS_BITS'(PAIR_GAP_CYCLES));
        sweep_dt = rise_ts + (width >> 1) - active_rise;
    end

    // Measurement FSM with registered strobes and sync/sweep bookkeeping
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state            <= ST_WAIT_LOW;
            rise_pend        <= 1'b0;
            rise_ts          <= '0;
            width            <= '0;
            prev_rise        <= '0;
            prev_tag         <= LH_B;
            active_valid     <= 1'b0;
            active_rise      <= '0;
            active_lh        <= LH_A;
            active_axis      <= 1'b0;
            ootx_bit_valid   <= 2'b00;
            ootx_bit         <= 1'b0;
            sync_axis        <= 1'b0;
            sync_skip        <= 1'b0;
            sweep_valid      <= 1'b0;
            sweep_lighthouse <= 1'b0;
            sweep_axis       <= 1'b0;
            sweep_cycles     <= '0;
            pulse_error      <= 1'b0;
            error_count      <= 8'd0;
        end else begin
            ootx_bit_valid <= 2'b00;
            sweep_valid    <= 1'b0;
            pulse_error    <= 1'b0;
            case (state)
                ST_WAIT_LOW: begin
                    if (!level) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    // A rise seen during CLASSIFY is one cycle old here, so
                    // back-date the timestamp and pre-count that cycle
                    if (rise_pend) begin
                        rise_pend <= 1'b0;
                        rise_ts   <= ts - TS_BITS'(1);
                        width     <= TS_BITS'(1);
                        state     <= fall ? ST_CLASSIFY : ST_HIGH;
                    end else if (rise) begin
                        rise_ts <= ts;
                        width   <= '0;
                        state   <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (width != '1) width <= width + TS_BITS'(1);
                    if (fall) state <= ST_CLASSIFY;
                end
                ST_CLASSIFY: begin
                    rise_pend <= rise;
                    state     <= ST_IDLE;
                    if (is_sync) begin
                        ootx_bit_valid <= tag_b ? 2'b10 : 2'b01;
                        ootx_bit       <= code[CODE_DATA];
                        sync_axis      <= code[CODE_AXIS];
                        sync_skip      <= code[CODE_SKIP];
                        prev_rise      <= rise_ts;
                        prev_tag       <= tag_b ? LH_B : LH_A;
                        // An A sync starts a new pair: drop the old reference
                        // unless this sync becomes the reference itself
                        if (!code[CODE_SKIP]) begin
                            active_valid <= 1'b1;
                            active_rise  <= rise_ts;
                            active_lh    <= tag_b ? LH_B : LH_A;
                            active_axis  <= code[CODE_AXIS];
                        end else if (!tag_b) begin
                            active_valid <= 1'b0;
                        end
                    end else if (is_sweep) begin
                        if (active_valid && (sweep_dt <= TS_BITS'(SWEEP_WINDOW_CYCLES))) begin
                            sweep_valid      <= 1'b1;
                            sweep_lighthouse <= active_lh;
                            sweep_axis       <= active_axis;
                            sweep_cycles     <= sweep_dt;
                        end
                    end else if (is_error) begin
                        pulse_error <= 1'b1;
                        if (error_count != 8'hFF) error_count <= error_count + 8'd1;
                    end
                end
                default: state <= ST_WAIT_LOW;
            endcase
        end
    end

endmodule

// File: doc/lighthouse_pulse_decoder.md
Name: lighthouse_pulse_decoder

Overview:
Front-end stage of the lighthouse tracking path. Takes one photodiode envelope signal, measures high-pulse widths and classifies each pulse as a sync pulse or a sweep pulse. Sync pulses are decoded into {skip, data, axis} bits and tagged to lighthouse A or B. The per-lighthouse data-bit strobes feed the OOTX frame decoder. Sweep pulses produce the sweep time relative to the active sync.

Parameters:
SYNC_BASE_CYCLES, 3125, sync width for code k=0 (62.5 us at 50 MHz)
SYNC_STEP_CYCLES, 521, width increment per code step (10.42 us)
SWEEP_MAX_CYCLES, 1500, maximum sweep pulse width (30 us)
PAIR_GAP_CYCLES, 25000, maximum rise-to-rise spacing for an A->B sync pair (500 us)
SWEEP_WINDOW_CYCLES, 450000, maximum sweep_cycles accepted (9 ms)
TS_BITS, 20, width of the width counter and of sweep_cycles

Ports:
clock  in  1  system clock (50 MHz)
reset_n  in  1  asynchronous active-low reset
sensor  in  1  raw envelope, active high, asynchronous to clock
ootx_bit_valid  out  2  one-cycle strobe; bit0 = lighthouse A, bit1 = lighthouse B
ootx_bit  out  1  decoded data bit, valid with ootx_bit_valid
sync_axis  out  1  axis bit of the last sync, valid with ootx_bit_valid
sync_skip  out  1  skip bit of the last sync, valid with ootx_bit_valid
sweep_valid  out  1  one-cycle strobe, sweep measurement ready
sweep_lighthouse  out  1  0 = A, 1 = B; lighthouse whose sync had skip=0
sweep_axis  out  1  axis of the referencing sync
sweep_cycles  out  TS_BITS  cycles from active sync rise to sweep pulse centre
pulse_error  out  1  one-cycle strobe, unclassifiable pulse
error_count  out  8  saturating count of pulse_error

Behaviour:
- Input path: sensor passes through a 2-flop synchroniser; edges are detected on the synchronised signal. Total latency is 2 cycles plus the edge register.
- Timestamp: free-running TS_BITS counter; wraps modulo 2^TS_BITS. All differences are computed modulo 2^TS_BITS.
- FSM states:
  - WAIT_LOW: entered from reset; leaves only when the synchronised sensor is low, then goes to IDLE. A pulse already high at reset release is never measured.
  - IDLE: on rising edge, latch rise_ts, clear width, go to HIGH.
  - HIGH: width increments, saturating at all-ones. On falling edge go to CLASSIFY.
  - CLASSIFY: one cycle; outputs assert on the following edge; return to IDLE.
- Latency: strobes assert exactly 2 clocks after the synchronised falling edge.
- Classification by width w:
  - w <= SWEEP_MAX_CYCLES: sweep.
  - w >= BASE - STEP/2 and w < BASE + 7*STEP + STEP/2: sync.
  - Anything else: pulse_error, and error_count increments (saturates at 255).
- Sync code: k = number of thresholds T_i = BASE + i*STEP - STEP/2 (i = 1..7) with w >= T_i. Uses comparators only, no divider. Bit mapping: k[2] = skip, k[1] = data, k[0] = axis.
- Lighthouse tag: a sync is B if the previous sync was tagged A and rise_ts - prev_sync_rise < PAIR_GAP_CYCLES; otherwise it is A. After a B, the next sync is always A.
- Active sync: a sync with skip=0 stores its rise_ts, lighthouse tag and axis, and sets active_valid.
- Any A-tagged sync clears active_valid before its own update, so a pair in which both syncs skip leaves no active sync.
- Sweep: sweep_cycles = (rise_ts + w/2) - active_rise, with w/2 truncated. It is emitted only if active_valid is set and sweep_cycles <= SWEEP_WINDOW_CYCLES; otherwise the pulse is silently dropped (not an error).
- Reset values: all strobes 0, ootx_bit/sync_axis/sync_skip/sweep_* 0, error_count 0, active_valid 0, prev tag = B (so the first sync is A).
- Reset mid-pulse: the measurement is abandoned and the FSM restarts in WAIT_LOW.
- Simultaneous events: a new rising edge arriving in the CLASSIFY cycle is captured in IDLE on the next cycle; the 2-flop path guarantees a minimum 1-cycle gap.

Optional Feature:
LIGHTHOUSE_GLITCH_FILTER_EN:
- Defined: a 4-cycle stability filter follows the synchroniser; a level change propagates only after 4 consecutive equal samples. Latency grows by 4 cycles. Widths are unchanged for clean pulses.
- Undefined: the synchronised signal is used directly.

Decomposition:
- Package lighthouse_pkg holds:
  - sync code field positions (SKIP=2, DATA=1, AXIS=0)
  - lighthouse index constants LH_A=0, LH_B=1
  - FSM state enum
  - default timing constants for 50 MHz
- Sub-module lighthouse_sync_classifier: combinational width -> {is_sweep, is_sync, code[2:0], is_error}, parameterised by BASE/STEP/SWEEP_MAX.

Test Plan:
1. Single high pulse of w = 3125 after reset -> ootx_bit_valid=01, skip=0, data=0, axis=0.
2. A sync w=3646 (k=1); B sync w=5730 (k=5) rising 20000 cycles later; sweep rising 200000 cycles after A rise with w=200.
   - A: valid=01, axis=1.
   - B: valid=10, skip=1, axis=1.
   - Sweep: sweep_valid, sweep_lighthouse=0, sweep_axis=1, sweep_cycles=200100.
3. Pulse w=2000, then pulse w=8000 -> two pulse_error strobes, error_count=2, no ootx strobes.
4. Two syncs spaced 30000 cycles apart -> both tagged A (ootx_bit_valid=01 each).
5. reset_n low for 10 cycles in the middle of a 3000-cycle pulse, sensor still high at release -> no output; the next clean pulse w=4167 (k=2) gives data=1, tag A.
6. With LIGHTHOUSE_GLITCH_FILTER_EN: 2-cycle low dropout inside a 3125 pulse -> single sync, k=0; without the macro -> two pulses and pulse_error.
